// File: rtl/hsi_com_line_sel.sv
// Command/data line-pair selector for the HSI master: routes the coder onto one of N_CH
// redundant com lines, tracks consecutive failures per line and fails over on request.
module hsi_com_line_sel #(
   parameter int N_CH      = 2,
   parameter int MAX_FAILS = 3,
   parameter bit STICKY    = 1'b0,
   localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CH_W-1:0]   base_ch,
   input  logic [N_CH-1:0]   ch_en,
   input  logic              switch_req,
   input  logic              frame_ok,
   input  logic              frame_to_reply_end,
   input  logic              clr_fail,
   input  logic              cd_q,
   input  logic [N_CH-1:0]   dat_in,
   output logic [N_CH-1:0]   com,
   output logic              dat_out,
   output logic [CH_W-1:0]   act_ch,
   output logic              switched,
   output logic [N_CH-1:0]   ch_failed,
   output logic              all_failed,
   output logic              no_alt
);

   // state | meaning
   // OFF   | just out of reset, all lines idle high
   // BASE  | following base_ch whenever it is usable
   // SW    | failed over to an alternative channel
   typedef enum logic [1:0] {OFF, BASE, SW} state_t;

   localparam int         N_PAD = 1 << CH_W;
   localparam logic [3:0] MAX_F = 4'(MAX_FAILS);

   state_t            state, state_nxt;
   logic [CH_W-1:0]   act_nxt;
   logic [3:0]        fail_cnt [N_PAD];
   logic [3:0]        cnt_nxt  [N_PAD];
   logic [N_PAD-1:0]  failed_q, failed_nxt;
   logic              no_alt_nxt;

   // Index-safe copies so a base_ch beyond N_CH reads as disabled.
   logic [N_PAD-1:0]  en_pad, dat_pad;
   logic              base_ok;
   logic              found;
   logic [CH_W-1:0]   cand, probe;
   int                idx;

   always_comb begin
      en_pad              = '0;
      en_pad[N_CH-1:0]    = ch_en;
      dat_pad             = '1;
      dat_pad[N_CH-1:0]   = dat_in;
   end

   assign base_ok = (int'(base_ch) < N_CH) && en_pad[base_ch] && !failed_q[base_ch];

   always_comb begin
      state_nxt  = state;
      act_nxt    = act_ch;
      cnt_nxt    = fail_cnt;
      failed_nxt = failed_q;
      no_alt_nxt = 1'b0;
      found      = 1'b0;
      cand       = '0;
      probe      = '0;
      idx        = 0;
      case (state)
         OFF: begin
            state_nxt = BASE;
            act_nxt   = (int'(base_ch) < N_CH) ? base_ch : '0;
         end
         default: begin
            if (clr_fail) begin
               for (int i = 0; i < N_PAD; i++) cnt_nxt[i] = 4'd0;
               failed_nxt = '0;
            end else if (switch_req) begin
               if (fail_cnt[act_ch] < MAX_F)
                  cnt_nxt[act_ch] = fail_cnt[act_ch] + 4'd1;
               if (cnt_nxt[act_ch] >= MAX_F)
                  failed_nxt[act_ch] = 1'b1;
               // Round-robin search starting just after the active channel.
               for (int k = 1; k < N_CH; k++) begin
                  idx   = (int'(act_ch) + k) % N_CH;
                  probe = CH_W'(idx);
                  if (!found && en_pad[probe] && !failed_nxt[probe]) begin
                     found = 1'b1;
                     cand  = probe;
                  end
               end
               if (found) begin
                  act_nxt   = cand;
                  state_nxt = SW;
               end else begin
                  no_alt_nxt = 1'b1;
               end
            end else begin
               if (frame_ok)
                  cnt_nxt[act_ch] = 4'd0;
               if (state == BASE) begin
                  if (base_ok) act_nxt = base_ch;
               end else if (frame_to_reply_end && !STICKY && base_ok) begin
                  act_nxt   = base_ch;
                  state_nxt = BASE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= OFF;
         act_ch   <= '0;
         failed_q <= '0;
         no_alt   <= 1'b0;
         for (int i = 0; i < N_PAD; i++) fail_cnt[i] <= 4'd0;
      end else begin
         state    <= state_nxt;
         act_ch   <= act_nxt;
         failed_q <= failed_nxt;
         no_alt   <= no_alt_nxt;
         for (int i = 0; i < N_PAD; i++) fail_cnt[i] <= cnt_nxt[i];
      end
   end

   assign ch_failed  = failed_q[N_CH-1:0];
   assign switched   = (state == SW);
   assign all_failed = &(ch_failed | ~ch_en);

   // Output routing is combinational so cd_q reaches the pin with no added latency.
   always_comb begin
      com = '1;
      if (state != OFF) begin
         for (int i = 0; i < N_CH; i++)
            if (act_ch == CH_W'(i) && ch_en[i]) com[i] = cd_q;
      end
   end

   assign dat_out = (state != OFF && en_pad[act_ch]) ? dat_pad[act_ch] : 1'b1;

endmodule

// File: tb/tb_hsi_com_line_sel.sv
// Directed bench for hsi_com_line_sel: two 2-channel instances (revert / sticky) sharing
// stimulus, plus a 4-channel instance for the skip-disabled search.
module tb_hsi_com_line_sel;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       base_ch;
   logic [1:0] ch_en;
   logic       switch_req, frame_ok, ftre, clr_fail, cd_q;
   logic [1:0] dat_in;

   logic [1:0] com0, com1;
   logic       dat_out0, dat_out1, act0, act1, sw0, sw1;
   logic [1:0] failed0, failed1;
   logic       allf0, allf1, no_alt0, no_alt1;

   logic [1:0] base_ch2;
   logic [3:0] ch_en2, dat_in2;
   logic       sw_req2, fok2, ftre2, clr2;
   logic [3:0] com2, failed2;
   logic [1:0] act2;
   logic       dat_out2, swd2, allf2, no_alt2;

   int checks = 0;
   int errors = 0;

   hsi_com_line_sel #(.N_CH(2), .MAX_FAILS(3), .STICKY(1'b0)) u_rev (
      .clk(clk), .rst(rst), .base_ch(base_ch), .ch_en(ch_en), .switch_req(switch_req),
      .frame_ok(frame_ok), .frame_to_reply_end(ftre), .clr_fail(clr_fail), .cd_q(cd_q),
      .dat_in(dat_in), .com(com0), .dat_out(dat_out0), .act_ch(act0), .switched(sw0),
      .ch_failed(failed0), .all_failed(allf0), .no_alt(no_alt0));

   hsi_com_line_sel #(.N_CH(2), .MAX_FAILS(3), .STICKY(1'b1)) u_stk (
      .clk(clk), .rst(rst), .base_ch(base_ch), .ch_en(ch_en), .switch_req(switch_req),
      .frame_ok(frame_ok), .frame_to_reply_end(ftre), .clr_fail(clr_fail), .cd_q(cd_q),
      .dat_in(dat_in), .com(com1), .dat_out(dat_out1), .act_ch(act1), .switched(sw1),
      .ch_failed(failed1), .all_failed(allf1), .no_alt(no_alt1));

   hsi_com_line_sel #(.N_CH(4), .MAX_FAILS(3), .STICKY(1'b0)) u_four (
      .clk(clk), .rst(rst), .base_ch(base_ch2), .ch_en(ch_en2), .switch_req(sw_req2),
      .frame_ok(fok2), .frame_to_reply_end(ftre2), .clr_fail(clr2), .cd_q(cd_q),
      .dat_in(dat_in2), .com(com2), .dat_out(dat_out2), .act_ch(act2), .switched(swd2),
      .ch_failed(failed2), .all_failed(allf2), .no_alt(no_alt2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_sw();
      switch_req = 1'b1; tick(); switch_req = 1'b0;
   endtask

   task automatic pulse_ftre();
      ftre = 1'b1; tick(); ftre = 1'b0;
   endtask

   task automatic reset_dut();
      rst = 1'b1; #1; rst = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1; base_ch = 1'b0; ch_en = 2'b11; switch_req = 1'b0; frame_ok = 1'b0;
      ftre = 1'b0; clr_fail = 1'b0; cd_q = 1'b0; dat_in = 2'b10;
      base_ch2 = 2'd1; ch_en2 = 4'b1011; dat_in2 = 4'b0001;
      sw_req2 = 1'b0; fok2 = 1'b0; ftre2 = 1'b0; clr2 = 1'b0;

      #3;
      chk("rst_com",      32'(com0), 32'h3);
      chk("rst_dat_out",  32'(dat_out0), 32'h1);
      chk("rst_act",      32'(act0), 32'h0);
      chk("rst_switched", 32'(sw0), 32'h0);
      chk("rst_failed",   32'(failed0), 32'h0);
      chk("rst_no_alt",   32'(no_alt0), 32'h0);

      @(negedge clk); rst = 1'b0;
      tick();
      chk("base_act",     32'(act0), 32'h0);
      chk("base_com",     32'(com0), 32'h2);
      chk("base_dat_out", 32'(dat_out0), 32'h0);

      pulse_sw();
      chk("sw_act",       32'(act0), 32'h1);
      chk("sw_switched",  32'(sw0), 32'h1);
      chk("sw_com_lo",    32'(com0), 32'h1);
      chk("sw_dat_out",   32'(dat_out0), 32'h1);
      cd_q = 1'b1; #1;
      chk("sw_com_hi",    32'(com0), 32'h3);
      cd_q = 1'b0;

      pulse_ftre();
      chk("rev_act",      32'(act0), 32'h0);
      chk("rev_switched", 32'(sw0), 32'h0);
      chk("stk_act",      32'(act1), 32'h1);
      chk("stk_switched", 32'(sw1), 32'h1);

      // failure counting on ch0, frame_ok in between resets the run
      reset_dut();
      pulse_sw(); pulse_ftre();
      pulse_sw(); pulse_ftre();
      frame_ok = 1'b1; tick(); frame_ok = 1'b0;
      pulse_sw(); pulse_ftre();
      chk("fok_not_failed", 32'(failed0), 32'h0);
      chk("fok_act",        32'(act0), 32'h0);
      pulse_sw(); pulse_ftre();
      pulse_sw();
      chk("max_failed",     32'(failed0), 32'h1);
      chk("max_act",        32'(act0), 32'h1);
      chk("max_all_failed", 32'(allf0), 32'h0);
      pulse_ftre();
      chk("base_bad_stay_act", 32'(act0), 32'h1);
      chk("base_bad_stay_sw",  32'(sw0), 32'h1);

      pulse_sw();
      chk("no_alt_pulse", 32'(no_alt0), 32'h1);
      chk("no_alt_act",   32'(act0), 32'h1);
      tick();
      chk("no_alt_clear", 32'(no_alt0), 32'h0);
      pulse_sw(); pulse_sw();
      chk("all_failed_flags", 32'(failed0), 32'h3);
      chk("all_failed",       32'(allf0), 32'h1);

      clr_fail = 1'b1; switch_req = 1'b1; tick(); clr_fail = 1'b0; switch_req = 1'b0;
      chk("clr_failed",  32'(failed0), 32'h0);
      chk("clr_act",     32'(act0), 32'h1);
      chk("clr_no_alt",  32'(no_alt0), 32'h0);
      chk("clr_all_f",   32'(allf0), 32'h0);
      pulse_ftre();
      chk("clr_rev_act", 32'(act0), 32'h0);
      chk("clr_rev_sw",  32'(sw0), 32'h0);

      // asynchronous reset in the middle of a cycle
      #1;
      chk("pre_rst_com", 32'(com0), 32'h2);
      @(negedge clk); #2; rst = 1'b1; #1;
      chk("mid_rst_com", 32'(com0), 32'h3);
      chk("mid_rst_dat", 32'(dat_out0), 32'h1);
      rst = 1'b0;
      tick();
      chk("post_rst_act", 32'(act0), 32'h0);

      // 4-channel search skipping disabled ch2
      reset_dut();
      chk("q_base_act", 32'(act2), 32'h1);
      sw_req2 = 1'b1; tick(); sw_req2 = 1'b0;
      chk("q_skip_act", 32'(act2), 32'h3);
      chk("q_skip_sw",  32'(swd2), 32'h1);
      sw_req2 = 1'b1; tick(); sw_req2 = 1'b0;
      chk("q_wrap_act", 32'(act2), 32'h0);
      chk("q_wrap_com", 32'(com2), 32'he);
      chk("q_wrap_dat", 32'(dat_out2), 32'h1);
      ftre2 = 1'b1; tick(); ftre2 = 1'b0;
      chk("q_rev_act",  32'(act2), 32'h1);
      chk("q_rev_sw",   32'(swd2), 32'h0);
      chk("q_rev_dat",  32'(dat_out2), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
